oc8051_int_ctrl: RTL and testbench
==================================

Name: oc8051_int_ctrl

Overview:
- Prioritised external-interrupt controller in front of oc8051_top.
- Conditions three active-low external lines: 2-flop sync, debounce, then edge or level detect.
- Holds per-source pending flags, applies enable and priority masks, and drives the core's int/int_v request.
- Tracks in-service levels through reti, allowing one level of nesting (high preempts low).

Parameters:
- VEC0, 8'h40, vector for source 0
- VEC1, 8'h50, vector for source 1
- VEC2, 8'h65, vector for source 2
- DEB_CYC, 4, consecutive stable synced samples required before a level change is accepted (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- irq_n  in  3  raw external lines, active-low, asynchronous
- ea  in  1  global enable
- ie  in  3  per-source enable
- ip  in  3  per-source priority (1 = high)
- it  in  3  per-source trigger (1 = falling edge, 0 = low level)
- reti  in  1  one-cycle pulse from core on RETI
- int_req  out  1  request to core int
- int_v  out  8  vector to core int_v
- int_act  out  1  any level in service
- act_lvl  out  2  {hi_active, lo_active}
- pend  out  3  pending flags

Behaviour:
- Reset values: int_req=0, int_v=8'h00, int_act=0, act_lvl=2'b00, pend=3'b000. Synchronisers and debounced levels reset to 1 (inactive); debounce counters reset to 0; FSM resets to IDLE.
- Conditioning, per source:
  - 2-flop sync, then debounce.
  - Debounced level changes only after DEB_CYC consecutive synced samples differ from it; the counter clears on any sample equal to the current level.
  - Edge event = debounced 1->0 transition (single cycle).
- Pending:
  - Edge mode: pend[i] set on edge event; cleared in the cycle source i is granted. Set wins over clear in the same cycle.
  - Level mode: pend[i] = ~debounced[i], never latched.
  - Writing it[i] while pending: the flag re-evaluates in the next cycle under the new mode.
- Eligibility:
  - elig[i] = pend[i] & ie[i] & ea.
  - A high candidate is elig & ip, allowed only if hi_active=0.
  - A low candidate is elig & ~ip, allowed only if hi_active=0 and lo_active=0.
  - Within a class, lowest index wins. High class beats low class.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if any allowed candidate, latch winner index and int_v=VECn, go to REQ.
  - REQ (exactly 1 cycle): int_req=1. Set hi_active or lo_active per the winner's ip, sampled at grant. Clear the winner's edge pend. Go to SERV.
  - SERV: int_req=0. On reti, clear hi_active if set, else lo_active.
  - SERV exit: once no active flags remain, go to IDLE. An allowed high candidate while only lo_active is set goes to REQ (nesting).
  - Latency: edge accepted at debounce output -> int_req at cycle +2 (pend at +1, REQ at +2).
- int_v: holds its last granted value outside REQ and is stable throughout REQ.
- int_act = hi_active | lo_active.
- reti with no active level: ignored.
- reti and a new candidate in the same cycle: reti is applied first; arbitration uses the updated flags on the next cycle.
- ea/ie dropping while pend is set: the flag is retained (edge mode) and the request fires once re-enabled.
- rst mid-service: all state returns to reset values in the same edge; pending edges are lost.

Decomposition:
- Package oc8051_int_defs: FSM state encodings (IDLE/REQ/SERV), default vector constants, NUM_SRC=3, debounce counter width (4).
- Sub-module oc8051_int_cond: one source's sync, debounce counter and edge detect. Outputs deb_lvl and edge. Instantiated three times.

Test Plan:
- Edge, single source: ea=1, ie=3'b001, it=3'b001, irq_n[0] low for 10 cycles.
  - After sync+DEB_CYC, pend=3'b001, then int_req pulses 1 cycle with int_v=8'h40; pend clears, int_act=1.
  - reti pulse -> int_act=0, back to IDLE.
- Simultaneous sources, ip=0: irq_n[1] and irq_n[2] fall in the same cycle.
  - 8'h50 is granted first.
  - After reti, 8'h65 is granted; no third request.
- Nesting: source 2 low priority in service (act_lvl=2'b01); source 0 with ip[0]=1 falls.
  - int_req with int_v=8'h40 and act_lvl=2'b11.
  - First reti -> 2'b01; second reti -> 2'b00.
- Low cannot preempt: source 1 high in service; source 0 low-priority edge arrives.
  - pend[0]=1, no int_req until reti, then int_v=8'h40.
- Level mode and debounce:
  - it[1]=0 with irq_n[1] held low: re-requests 8'h50 after each reti.
  - A 3-cycle glitch with DEB_CYC=4 produces no pend.
- Reset and masking:
  - rst asserted during SERV -> all outputs zero next cycle.
  - Edge arriving with ea=0 leaves pend set; raising ea -> int_req within 2 cycles.

Source files
------------

// File: rtl/oc8051_int_ctrl_pkg.sv
// Shared definitions for the oc8051 external interrupt controller:
// FSM state encoding, source count, debounce counter width, default vectors
// and the fixed-priority pick used inside each priority class.
package oc8051_int_defs;

    localparam int NUM_SRC = 3;
    localparam int DEB_W   = 4;

    localparam logic [7:0] VEC0_DEF = 8'h40;
    localparam logic [7:0] VEC1_DEF = 8'h50;
    localparam logic [7:0] VEC2_DEF = 8'h65;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } int_state_t;

    // Lowest set bit wins; an empty mask returns 0 and callers gate on "any".
    function automatic logic [1:0] lowest_idx(input logic [NUM_SRC-1:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/oc8051_int_cond.sv
// Conditioning for one active-low external interrupt line: two-flop
// synchroniser, debounce filter, and falling-edge detect on the debounced level.
// The edge output is called edge_evt because "edge" is a reserved word.
module oc8051_int_cond
    import oc8051_int_defs::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_n,
    output logic deb_lvl,
    output logic edge_evt
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             deb_prev;
    logic [DEB_W-1:0] cnt;

    // Synchronise the raw line, then accept a new level only after DEB_CYC
    // consecutive synced samples disagree with the current debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            deb_lvl  <= 1'b1;
            deb_prev <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= irq_n;
            sync2    <= sync1;
            deb_prev <= deb_lvl;
            if (sync2 == deb_lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_lvl <= sync2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Single-cycle pulse in the cycle the debounced level has just fallen.
    assign edge_evt = deb_prev & ~deb_lvl;

endmodule

// File: rtl/oc8051_int_ctrl.sv
// Prioritised three-source external interrupt controller feeding the
// oc8051 core's int/int_v inputs, with one level of nesting (high over low).
module oc8051_int_ctrl
    import oc8051_int_defs::*;
#(
    parameter logic [7:0] VEC0    = VEC0_DEF,
    parameter logic [7:0] VEC1    = VEC1_DEF,
    parameter logic [7:0] VEC2    = VEC2_DEF,
    parameter int         DEB_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic               ea,
    input  logic [NUM_SRC-1:0] ie,
    input  logic [NUM_SRC-1:0] ip,
    input  logic [NUM_SRC-1:0] it,
    input  logic               reti,
    output logic               int_req,
    output logic [7:0]         int_v,
    output logic               int_act,
    output logic [1:0]         act_lvl,
    output logic [NUM_SRC-1:0] pend
);

    int_state_t         state;
    logic [1:0]         win_idx;
    logic               hi_active;
    logic               lo_active;

    logic [NUM_SRC-1:0] deb;
    logic [NUM_SRC-1:0] edge_evt;
    logic [NUM_SRC-1:0] grant_clr;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] hi_cand;
    logic [NUM_SRC-1:0] lo_cand;
    logic               any_hi;
    logic               any_cand;
    logic [1:0]         win_next;
    logic [7:0]         vec_next;
    logic               win_ip;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_cond
            oc8051_int_cond #(
                .DEB_CYC (DEB_CYC)
            ) u_cond (
                .clk      (clk),
                .rst      (rst),
                .irq_n    (irq_n[g]),
                .deb_lvl  (deb[g]),
                .edge_evt (edge_evt[g])
            );
        end
    endgenerate

    // Grant decode, arbitration masks and the winner's vector and priority.
    always_comb begin
        grant_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_clr[i] = (state == ST_REQ) && (win_idx == 2'(i));
        end

        elig     = pend & ie & {NUM_SRC{ea}};
        hi_cand  = elig & ip & {NUM_SRC{~hi_active}};
        lo_cand  = elig & ~ip & {NUM_SRC{~hi_active & ~lo_active}};
        any_hi   = |hi_cand;
        any_cand = any_hi | (|lo_cand);
        win_next = any_hi ? lowest_idx(hi_cand) : lowest_idx(lo_cand);

        case (win_next)
            2'd0:    vec_next = VEC0;
            2'd1:    vec_next = VEC1;
            default: vec_next = VEC2;
        endcase

        case (win_idx)
            2'd0:    win_ip = ip[0];
            2'd1:    win_ip = ip[1];
            default: win_ip = ip[2];
        endcase
    end

    // Pending flags: edge mode latches until granted (set beats clear),
    // level mode follows the debounced line one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (it[i]) pend[i] <= edge_evt[i] | (pend[i] & ~grant_clr[i]);
                else       pend[i] <= ~deb[i];
            end
        end
    end

    // Request/service FSM with registered request, vector and in-service flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_idx   <= 2'd0;
            int_req   <= 1'b0;
            int_v     <= 8'h00;
            hi_active <= 1'b0;
            lo_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_cand) begin
                        win_idx <= win_next;
                        int_v   <= vec_next;
                        int_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    int_req <= 1'b0;
                    if (win_ip) hi_active <= 1'b1;
                    else        lo_active <= 1'b1;
                    state <= ST_SERV;
                end
                ST_SERV: begin
                    if (reti) begin
                        if (hi_active)      hi_active <= 1'b0;
                        else if (lo_active) lo_active <= 1'b0;
                    end else if (!hi_active && !lo_active) begin
                        state <= ST_IDLE;
                    end else if (any_hi) begin
                        win_idx <= win_next;
                        int_v   <= vec_next;
                        int_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    assign int_act = hi_active | lo_active;
    assign act_lvl = {hi_active, lo_active};

endmodule

// File: tb/tb_oc8051_int_ctrl.sv
// Self-checking bench for oc8051_int_ctrl: a per-cycle vector table for the
// single-source edge flow and debounce glitch, then directed multi-cycle
// sequences for arbitration, nesting, level mode, reset and masking.
module tb_oc8051_int_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] irq_n;
    logic       ea;
    logic [2:0] ie;
    logic [2:0] ip;
    logic [2:0] it;
    logic       reti;
    logic       int_req;
    logic [7:0] int_v;
    logic       int_act;
    logic [1:0] act_lvl;
    logic [2:0] pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] irq_n;
        logic       reti;
        logic       exp_req;
        logic [7:0] exp_v;
        logic       exp_act;
        logic [1:0] exp_lvl;
        logic [2:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    oc8051_int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .irq_n   (irq_n),
        .ea      (ea),
        .ie      (ie),
        .ip      (ip),
        .it      (it),
        .reti    (reti),
        .int_req (int_req),
        .int_v   (int_v),
        .int_act (int_act),
        .act_lvl (act_lvl),
        .pend    (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addRow(input logic [2:0] irq, input logic rt,
                                   input logic req, input logic [7:0] v,
                                   input logic act, input logic [1:0] lvl,
                                   input logic [2:0] pd);
        vec_t r;
        r.irq_n = irq; r.reti = rt; r.exp_req = req; r.exp_v = v;
        r.exp_act = act; r.exp_lvl = lvl; r.exp_pend = pd;
        vecs.push_back(r);
    endfunction

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] irq, input logic rt);
        irq_n = irq;
        reti  = rt;
        step();
    endtask

    task automatic doReset();
        rst   = 1'b1;
        irq_n = 3'b111;
        reti  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulseReti();
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    // Step until int_req is seen, at most budget cycles; expiry is a failure.
    task automatic waitReq(input string name, input int budget);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (int_req === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: int_req stayed 0 for %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic countReq(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (int_req === 1'b1) cnt++;
        end
    endtask

    initial begin
        int nreq;

        // Single-source edge flow, then a 3-cycle glitch that must be filtered.
        for (int r = 1; r <= 6; r++) addRow(3'b110, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b000);
        addRow(3'b110, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 3'b001);
        addRow(3'b110, 1'b0, 1'b1, 8'h40, 1'b0, 2'b00, 3'b001);
        addRow(3'b110, 1'b0, 1'b0, 8'h40, 1'b1, 2'b01, 3'b000);
        addRow(3'b110, 1'b0, 1'b0, 8'h40, 1'b1, 2'b01, 3'b000);
        addRow(3'b111, 1'b0, 1'b0, 8'h40, 1'b1, 2'b01, 3'b000);
        addRow(3'b111, 1'b1, 1'b0, 8'h40, 1'b0, 2'b00, 3'b000);
        for (int r = 13; r <= 17; r++) addRow(3'b111, 1'b0, 1'b0, 8'h40, 1'b0, 2'b00, 3'b000);
        for (int r = 18; r <= 20; r++) addRow(3'b110, 1'b0, 1'b0, 8'h40, 1'b0, 2'b00, 3'b000);
        for (int r = 21; r <= 28; r++) addRow(3'b111, 1'b0, 1'b0, 8'h40, 1'b0, 2'b00, 3'b000);

        rst = 1'b1; irq_n = 3'b111; ea = 1'b1; ie = 3'b001; ip = 3'b000;
        it = 3'b001; reti = 1'b0;
        step();
        step();
        checkOutput("reset int_req", {7'd0, int_req}, 8'h00);
        checkOutput("reset int_v",   int_v,           8'h00);
        checkOutput("reset int_act", {7'd0, int_act}, 8'h00);
        checkOutput("reset act_lvl", {6'd0, act_lvl}, 8'h00);
        checkOutput("reset pend",    {5'd0, pend},    8'h00);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].irq_n, vecs[i].reti);
            checkOutput($sformatf("row%0d int_req", i + 1), {7'd0, int_req}, {7'd0, vecs[i].exp_req});
            checkOutput($sformatf("row%0d int_v",   i + 1), int_v, vecs[i].exp_v);
            checkOutput($sformatf("row%0d int_act", i + 1), {7'd0, int_act}, {7'd0, vecs[i].exp_act});
            checkOutput($sformatf("row%0d act_lvl", i + 1), {6'd0, act_lvl}, {6'd0, vecs[i].exp_lvl});
            checkOutput($sformatf("row%0d pend",    i + 1), {5'd0, pend}, {5'd0, vecs[i].exp_pend});
        end
        reti = 1'b0;

        // Simultaneous low-priority sources: index 1 first, then index 2 once.
        doReset();
        ea = 1'b1; ie = 3'b111; ip = 3'b000; it = 3'b111;
        irq_n = 3'b001;
        waitReq("simul first req", 20);
        checkOutput("simul first vector", int_v, 8'h50);
        step();
        checkOutput("simul pend after grant", {5'd0, pend}, 8'h04);
        checkOutput("simul act_lvl", {6'd0, act_lvl}, 8'h01);
        irq_n = 3'b111;
        pulseReti();
        waitReq("simul second req", 10);
        checkOutput("simul second vector", int_v, 8'h65);
        step();
        checkOutput("simul pend drained", {5'd0, pend}, 8'h00);
        pulseReti();
        countReq(15, nreq);
        checkOutput("simul no third req", nreq[7:0], 8'h00);

        // Nesting: high-priority source 0 preempts low-priority source 2.
        doReset();
        ea = 1'b1; ie = 3'b101; ip = 3'b000; it = 3'b101;
        irq_n = 3'b011;
        waitReq("nest low req", 20);
        checkOutput("nest low vector", int_v, 8'h65);
        step();
        checkOutput("nest lvl low", {6'd0, act_lvl}, 8'h01);
        ip = 3'b001;
        irq_n = 3'b110;
        waitReq("nest high req", 20);
        checkOutput("nest high vector", int_v, 8'h40);
        step();
        checkOutput("nest lvl both", {6'd0, act_lvl}, 8'h03);
        pulseReti();
        checkOutput("nest first reti", {6'd0, act_lvl}, 8'h01);
        pulseReti();
        checkOutput("nest second reti", {6'd0, act_lvl}, 8'h00);

        // Low priority cannot preempt an in-service high-priority source.
        doReset();
        ea = 1'b1; ie = 3'b011; ip = 3'b010; it = 3'b011;
        irq_n = 3'b101;
        waitReq("nopre high req", 20);
        checkOutput("nopre high vector", int_v, 8'h50);
        step();
        checkOutput("nopre lvl high", {6'd0, act_lvl}, 8'h02);
        irq_n = 3'b110;
        countReq(12, nreq);
        checkOutput("nopre blocked", nreq[7:0], 8'h00);
        checkOutput("nopre pend held", {5'd0, pend}, 8'h01);
        irq_n = 3'b111;
        pulseReti();
        waitReq("nopre low req after reti", 6);
        checkOutput("nopre low vector", int_v, 8'h40);
        step();
        checkOutput("nopre lvl low", {6'd0, act_lvl}, 8'h01);

        // Level mode: a held-low line re-requests after every reti.
        doReset();
        ea = 1'b1; ie = 3'b010; ip = 3'b000; it = 3'b000;
        irq_n = 3'b101;
        waitReq("level req 1", 20);
        checkOutput("level vector 1", int_v, 8'h50);
        step();
        pulseReti();
        waitReq("level req 2", 6);
        checkOutput("level vector 2", int_v, 8'h50);
        step();
        pulseReti();
        waitReq("level req 3", 6);
        checkOutput("level vector 3", int_v, 8'h50);
        irq_n = 3'b111;
        countReq(12, nreq);
        checkOutput("level no req in service", nreq[7:0], 8'h00);
        pulseReti();
        countReq(10, nreq);
        checkOutput("level no req released", nreq[7:0], 8'h00);
        checkOutput("level pend released", {5'd0, pend}, 8'h00);

        // Reset during service clears everything and drops the request.
        doReset();
        ea = 1'b1; ie = 3'b001; ip = 3'b000; it = 3'b001;
        irq_n = 3'b110;
        waitReq("rst req", 20);
        step();
        checkOutput("rst in service", {7'd0, int_act}, 8'h01);
        rst = 1'b1;
        irq_n = 3'b111;
        step();
        checkOutput("rst int_req", {7'd0, int_req}, 8'h00);
        checkOutput("rst int_v",   int_v,           8'h00);
        checkOutput("rst int_act", {7'd0, int_act}, 8'h00);
        checkOutput("rst act_lvl", {6'd0, act_lvl}, 8'h00);
        checkOutput("rst pend",    {5'd0, pend},    8'h00);
        rst = 1'b0;
        countReq(12, nreq);
        checkOutput("rst no req after", nreq[7:0], 8'h00);

        // Masked edge is retained and fires promptly once ea is raised.
        ea = 1'b0; ie = 3'b001; ip = 3'b000; it = 3'b001;
        irq_n = 3'b110;
        countReq(12, nreq);
        checkOutput("mask no req", nreq[7:0], 8'h00);
        checkOutput("mask pend held", {5'd0, pend}, 8'h01);
        irq_n = 3'b111;
        ea = 1'b1;
        waitReq("mask req on ea", 2);
        checkOutput("mask vector", int_v, 8'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
